// File: rtl/image_loader.sv
// Byte-stream frame parser: header + IMG_W/8 pixel bytes -> one image word with start pulse.
// start one cycle after last pixel xfer; in_ready low from ISSUE until cu_done.
module image_loader #(
  parameter int          IMG_W     = 32,
  parameter int unsigned MAX_LABEL = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             cu_done,
  output logic             start,
  output logic             train,
  output logic [7:0]       label_out,
  output logic [IMG_W-1:0] image_out,
  output logic             frame_err,
  output logic             busy
);

  localparam int NB = IMG_W / 8;
  localparam int CW = $clog2(NB) + 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_PIX,
    S_DROP,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       hdr_q, hdr_d;
  logic [IMG_W-1:0] sh_q, sh_d;
  logic             start_q, start_d;
  logic             train_q, train_d;
  logic [7:0]       label_q, label_d;
  logic [IMG_W-1:0] image_q, image_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  logic             xfer;
  logic             label_ok;
  logic [IMG_W-1:0] sh_next;

  assign in_ready = ~rst & ((state_q == S_HDR) | (state_q == S_PIX) | (state_q == S_DROP));
  assign xfer     = in_valid & in_ready;
  assign label_ok = (32'(in_data[3:0]) <= MAX_LABEL);
  // Shift form keeps IMG_W == 8 legal (no negative part-select).
  assign sh_next  = (sh_q << 8) | IMG_W'(in_data);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    sh_d        = sh_q;
    start_d     = 1'b0;
    train_d     = train_q;
    label_d     = label_q;
    image_d     = image_q;
    frame_err_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      S_HDR: begin
        busy_d = 1'b0;
        if (xfer) begin
          hdr_d   = in_data;
          cnt_d   = '0;
          state_d = label_ok ? S_PIX : S_DROP;
        end
      end
      S_PIX: begin
        if (xfer) begin
          sh_d = sh_next;
          if (cnt_q == LAST) begin
            train_d = hdr_q[7];
            label_d = {4'b0, hdr_q[3:0]};
            image_d = sh_next;
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DROP: begin
        if (xfer) begin
          if (cnt_q == LAST) begin
            frame_err_d = 1'b1;
            state_d     = S_HDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (cu_done) begin
          busy_d  = 1'b0;
          state_d = S_HDR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cu_done) begin
          busy_d  = 1'b0;
          state_d = S_HDR;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_HDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      cnt_q       <= '0;
      hdr_q       <= '0;
      sh_q        <= '0;
      start_q     <= 1'b0;
      train_q     <= 1'b0;
      label_q     <= '0;
      image_q     <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      sh_q        <= sh_d;
      start_q     <= start_d;
      train_q     <= train_d;
      label_q     <= label_d;
      image_q     <= image_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign start     = start_q;
  assign train     = train_q;
  assign label_out = label_q;
  assign image_out = image_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
